// File: rtl/ape_seq_pkg.sv
// Shared definitions for the APE sequencer: FSM encoding and instruction layout.
// Optional build macro APE_SEQ_STEP_EN adds the HALT (single-step) state.
package ape_seq_pkg;

  localparam int OP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CONFIG,
    ST_EXEC,
    ST_WB,
`ifdef APE_SEQ_STEP_EN
    ST_HALT,
`endif
    ST_DONE
  } state_e;

  // Instruction word is packed as {op, src0, src1, dst}, dst in the LSBs.
  function automatic int instr_w(input int rw);
    return OP_W + 3 * rw;
  endfunction

endpackage

// File: rtl/ape_regfile.sv
// Operand register file: two async operand reads, one registered host read, one write port.
module ape_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_NUM   = 8,
  localparam int RW        = $clog2(DATA_NUM)
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic [RW-1:0]         rd0_addr,
  output logic [DATA_WIDTH-1:0] rd0_data,
  input  logic [RW-1:0]         rd1_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  input  logic [RW-1:0]         host_addr,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  input  logic                  wr_en,
  input  logic [RW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DATA_NUM];

  // Contents deliberately survive reset.
  always_ff @(posedge gclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd0_data = mem[rd0_addr];
  assign rd1_data = mem[rd1_addr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) host_rd_data <= '0;
    else         host_rd_data <= mem[host_addr];
  end

endmodule

// File: rtl/ape_sequencer.sv
// Steps one APE through a stored program: FETCH, CONFIG, EXEC, WB per instruction.
// Build macro APE_SEQ_STEP_EN adds a `step` input and a HALT state between instructions.
module ape_sequencer
  import ape_seq_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_NUM        = 8,
  parameter int INSTRUCTION_NUM = 16,
  localparam int RW             = $clog2(DATA_NUM),
  localparam int IW             = $clog2(INSTRUCTION_NUM)
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  progWrEn,
  input  logic [IW-1:0]         progAddr,
  input  logic [OP_W-1:0]       progOp,
  input  logic [RW-1:0]         progSrc0,
  input  logic [RW-1:0]         progSrc1,
  input  logic [RW-1:0]         progDst,
  input  logic                  rfWrEn,
  input  logic [RW-1:0]         rfAddr,
  input  logic [DATA_WIDTH-1:0] rfWrData,
  output logic [DATA_WIDTH-1:0] rfRdData,
  input  logic                  start,
  input  logic [IW-1:0]         lastInstr,
`ifdef APE_SEQ_STEP_EN
  input  logic                  step,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  peConfigure,
  output logic [OP_W-1:0]       peOperationConf,
  output logic [RW-1:0]         peDataIn0Conf,
  output logic [RW-1:0]         peDataIn1Conf,
  output logic [RW-1:0]         peDataOutConf,
  output logic [IW-1:0]         peInstructionNumberConf,
  output logic [DATA_WIDTH-1:0] peDataIn0,
  output logic [DATA_WIDTH-1:0] peDataIn1,
  input  logic [DATA_WIDTH-1:0] peDataOut
);

  localparam int INSTR_W = instr_w(RW);

  state_e state_q, state_d;
  logic [IW-1:0] pc_q, last_q;
  logic [INSTR_W-1:0] store [INSTRUCTION_NUM];
  logic [DATA_WIDTH-1:0] rd0_data, rd1_data;
  logic rf_wr_en;
  logic [RW-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0] rf_wr_data;
  logic idle;

  assign idle = (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (idle && progWrEn) store[progAddr] <= {progOp, progSrc0, progSrc1, progDst};
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_CONFIG;
      ST_CONFIG: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB: begin
        if (pc_q == last_q) state_d = ST_DONE;
`ifdef APE_SEQ_STEP_EN
        else                state_d = ST_HALT;
`else
        else                state_d = ST_FETCH;
`endif
      end
`ifdef APE_SEQ_STEP_EN
      ST_HALT:   if (step) state_d = ST_FETCH;
`endif
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The configuration registers double as the instruction register: loaded as
  // FETCH hands over to CONFIG and held until the next instruction's CONFIG.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pc_q                    <= '0;
      last_q                  <= '0;
      peOperationConf         <= '0;
      peDataIn0Conf           <= '0;
      peDataIn1Conf           <= '0;
      peDataOutConf           <= '0;
      peInstructionNumberConf <= '0;
      peDataIn0               <= '0;
      peDataIn1               <= '0;
    end else begin
      if (idle && start) begin
        last_q <= lastInstr;
        pc_q   <= '0;
      end
      if (state_q == ST_FETCH) begin
        {peOperationConf, peDataIn0Conf, peDataIn1Conf, peDataOutConf} <= store[pc_q];
        peInstructionNumberConf <= pc_q;
      end
      // Operands latch before WB, so src == dst sees the old value.
      if (state_q == ST_CONFIG) begin
        peDataIn0 <= rd0_data;
        peDataIn1 <= rd1_data;
      end
      if (state_q == ST_WB && pc_q != last_q) pc_q <= pc_q + 1'b1;
    end
  end

  assign rf_wr_en   = (idle && rfWrEn) || (state_q == ST_WB);
  assign rf_wr_addr = (state_q == ST_WB) ? peDataOutConf : rfAddr;
  assign rf_wr_data = (state_q == ST_WB) ? peDataOut : rfWrData;

  ape_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_NUM   (DATA_NUM)
  ) u_rf (
    .gclk         (clk),
    .grst_n       (rstN),
    .rd0_addr     (peDataIn0Conf),
    .rd0_data     (rd0_data),
    .rd1_addr     (peDataIn1Conf),
    .rd1_data     (rd1_data),
    .host_addr    (rfAddr),
    .host_rd_data (rfRdData),
    .wr_en        (rf_wr_en),
    .wr_addr      (rf_wr_addr),
    .wr_data      (rf_wr_data)
  );

  assign busy        = !idle;
  assign done        = (state_q == ST_DONE);
  assign peConfigure = (state_q == ST_CONFIG);

endmodule

// File: tb/tb_ape_sequencer.sv
// Directed bench for ape_sequencer with a behavioural APE (ADD/SUB/AND/OR/XOR).
module tb_ape_sequencer;

  localparam int DW = 32;
  localparam int RW = 3;
  localparam int IW = 4;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4;

  logic clk = 1'b0;
  logic rstN;
  logic progWrEn, rfWrEn, start;
  logic [IW-1:0] progAddr, lastInstr;
  logic [3:0] progOp;
  logic [RW-1:0] progSrc0, progSrc1, progDst, rfAddr;
  logic [DW-1:0] rfWrData, rfRdData;
  logic busy, done, peConfigure;
  logic [3:0] peOperationConf;
  logic [RW-1:0] peDataIn0Conf, peDataIn1Conf, peDataOutConf;
  logic [IW-1:0] peInstructionNumberConf;
  logic [DW-1:0] peDataIn0, peDataIn1, peDataOut;
`ifdef APE_SEQ_STEP_EN
  logic step;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ape_sequencer #(.DATA_WIDTH(DW), .DATA_NUM(8), .INSTRUCTION_NUM(16)) dut (
    .clk(clk), .rstN(rstN),
    .progWrEn(progWrEn), .progAddr(progAddr), .progOp(progOp),
    .progSrc0(progSrc0), .progSrc1(progSrc1), .progDst(progDst),
    .rfWrEn(rfWrEn), .rfAddr(rfAddr), .rfWrData(rfWrData), .rfRdData(rfRdData),
    .start(start), .lastInstr(lastInstr),
`ifdef APE_SEQ_STEP_EN
    .step(step),
`endif
    .busy(busy), .done(done), .peConfigure(peConfigure),
    .peOperationConf(peOperationConf), .peDataIn0Conf(peDataIn0Conf),
    .peDataIn1Conf(peDataIn1Conf), .peDataOutConf(peDataOutConf),
    .peInstructionNumberConf(peInstructionNumberConf),
    .peDataIn0(peDataIn0), .peDataIn1(peDataIn1), .peDataOut(peDataOut)
  );

  always_comb begin
    case (peOperationConf)
      OP_ADD:  peDataOut = peDataIn0 + peDataIn1;
      OP_SUB:  peDataOut = peDataIn0 - peDataIn1;
      OP_AND:  peDataOut = peDataIn0 & peDataIn1;
      OP_OR:   peDataOut = peDataIn0 | peDataIn1;
      OP_XOR:  peDataOut = peDataIn0 ^ peDataIn1;
      default: peDataOut = peDataIn0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr_rf(input logic [RW-1:0] a, input logic [DW-1:0] d);
    rfWrEn = 1'b1; rfAddr = a; rfWrData = d;
    cyc();
    rfWrEn = 1'b0;
  endtask

  task automatic rd_rf(input logic [RW-1:0] a, output logic [DW-1:0] d);
    rfAddr = a;
    cyc();
    d = rfRdData;
  endtask

  task automatic wr_prog(input logic [IW-1:0] a, input logic [3:0] op,
                         input logic [RW-1:0] s0, input logic [RW-1:0] s1, input logic [RW-1:0] d);
    progWrEn = 1'b1; progAddr = a; progOp = op; progSrc0 = s0; progSrc1 = s1; progDst = d;
    cyc();
    progWrEn = 1'b0;
  endtask

  function automatic int exp_done(input int n);
`ifdef APE_SEQ_STEP_EN
    return 4 * n + 1 + (n - 1);  // one HALT cycle per boundary with step held high
`else
    return 4 * n + 1;
`endif
  endfunction

  // Runs n instructions; with interfere, drives host writes and extra start pulses mid-run.
  task automatic run(input int n, input bit interfere, output int done_cyc,
                     output int cfg_cyc, output logic [DW-1:0] in0_c3);
    lastInstr = IW'(n - 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    done_cyc = -1; cfg_cyc = -1; in0_c3 = '0;
    for (int k = 1; k < 300; k++) begin
      if (peConfigure && cfg_cyc < 0) cfg_cyc = k;
      if (k == 3) in0_c3 = peDataIn0;
      if (interfere) begin
        progWrEn = (k >= 2 && k <= 6);
        progAddr = '0; progOp = OP_SUB; progSrc0 = 3'd2; progSrc1 = 3'd1; progDst = 3'd7;
        rfWrEn = (k >= 2 && k <= 6);
        rfAddr = 3'd1; rfWrData = 32'd99;
        start = (k == 3);
      end
      if (done) begin
        done_cyc = k;
        chk("busy_at_done", 32'(busy), 32'd1);
        if (interfere) start = 1'b1;
        break;
      end
      cyc();
    end
    progWrEn = 1'b0; rfWrEn = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'(done), 32'd1);
    cyc();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("done_one_cycle", 32'(done), 32'd0);
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0]    op;
    logic [RW-1:0] s0, s1, d;
    logic [DW-1:0] a, b, exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, cc;
    logic [DW-1:0] in0, v;

    vt[0] = '{OP_ADD, 3'd1, 3'd2, 3'd3, 32'd5,         32'd7,     32'd12};
    vt[1] = '{OP_SUB, 3'd2, 3'd1, 3'd0, 32'd10,        32'd3,     32'd7};
    vt[2] = '{OP_AND, 3'd3, 3'd4, 3'd5, 32'h0000_F0F0, 32'hFF00,  32'h0000_F000};
    vt[3] = '{OP_OR,  3'd6, 3'd7, 3'd6, 32'h0F,        32'hF0,    32'hFF};
    vt[4] = '{OP_XOR, 3'd0, 3'd5, 3'd7, 32'hFFFF_FFFF, 32'd1,     32'hFFFF_FFFE};
    vt[5] = '{OP_ADD, 3'd1, 3'd2, 3'd3, 32'hFFFF_FFFF, 32'd2,     32'd1};

    rstN = 1'b0; progWrEn = 0; rfWrEn = 0; start = 0;
    progAddr = '0; progOp = '0; progSrc0 = '0; progSrc1 = '0; progDst = '0;
    rfAddr = '0; rfWrData = '0; lastInstr = '0;
`ifdef APE_SEQ_STEP_EN
    step = 1'b1;
`endif
    cyc(); cyc();
    chk("rst_busy_done_cfg", {29'd0, busy, done, peConfigure}, 32'd0);
    chk("rst_conf", 32'({peOperationConf, peDataIn0Conf, peDataIn1Conf, peDataOutConf, peInstructionNumberConf}), 32'd0);
    chk("rst_in0", peDataIn0, 32'd0);
    chk("rst_in1", peDataIn1, 32'd0);
    chk("rst_rfrd", rfRdData, 32'd0);
    rstN = 1'b1;
    cyc();

    // Single-instruction vectors
    foreach (vt[i]) begin
      wr_rf(vt[i].s0, vt[i].a);
      wr_rf(vt[i].s1, vt[i].b);
      wr_prog('0, vt[i].op, vt[i].s0, vt[i].s1, vt[i].d);
      run(1, 1'b0, dc, cc, in0);
      chk($sformatf("vec%0d_done_cyc", i), 32'(dc), 32'd5);
      chk($sformatf("vec%0d_cfg_cyc", i), 32'(cc), 32'd2);
      chk($sformatf("vec%0d_in0", i), in0, vt[i].a);
      rd_rf(vt[i].d, v);
      chk($sformatf("vec%0d_result", i), v, vt[i].exp);
    end

    // Dependent chain: r3=5+7, r4=r3+r1=17, r5=r4-r2=10
    wr_rf(3'd1, 32'd5); wr_rf(3'd2, 32'd7);
    wr_prog(4'd0, OP_ADD, 3'd1, 3'd2, 3'd3);
    wr_prog(4'd1, OP_ADD, 3'd3, 3'd1, 3'd4);
    wr_prog(4'd2, OP_SUB, 3'd4, 3'd2, 3'd5);
    run(3, 1'b0, dc, cc, in0);
    chk("chain_done_cyc", 32'(dc), 32'(exp_done(3)));
    rd_rf(3'd4, v); chk("chain_r4", v, 32'd17);
    rd_rf(3'd5, v); chk("chain_r5", v, 32'd10);

    // src0 == dst: operand is the old value
    wr_rf(3'd4, 32'd3); wr_rf(3'd5, 32'd1);
    wr_prog(4'd0, OP_ADD, 3'd4, 3'd5, 3'd4);
    run(1, 1'b0, dc, cc, in0);
    chk("srcdst_in0_old", in0, 32'd3);
    rd_rf(3'd4, v); chk("srcdst_r4", v, 32'd4);

    // Host writes and start ignored during a run
    wr_rf(3'd1, 32'd5); wr_rf(3'd2, 32'd7); wr_rf(3'd7, 32'd0);
    wr_prog(4'd0, OP_ADD, 3'd1, 3'd2, 3'd6);
    wr_prog(4'd1, OP_ADD, 3'd6, 3'd1, 3'd7);
    run(2, 1'b1, dc, cc, in0);
    chk("busyrun_done_cyc", 32'(dc), 32'(exp_done(2)));
    rd_rf(3'd1, v); chk("busyrun_r1_kept", v, 32'd5);
    rd_rf(3'd7, v); chk("busyrun_r7", v, 32'd17);
    wr_rf(3'd7, 32'd0);
    run(2, 1'b0, dc, cc, in0);
    chk("busyrun_rerun_cyc", 32'(dc), 32'(exp_done(2)));
    rd_rf(3'd7, v); chk("busyrun_store_kept", v, 32'd17);

    // Reset during cycle 6 of a 2-instruction run
    wr_rf(3'd7, 32'd0);
    lastInstr = 4'd1; start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k < 6; k++) cyc();
    chk("mid_cfg_before_rst", 32'(peConfigure), 32'd1);
    rstN = 1'b0; #1;
    chk("midrst_busy_done_cfg", {29'd0, busy, done, peConfigure}, 32'd0);
    chk("midrst_conf", 32'({peOperationConf, peDataIn0Conf, peDataIn1Conf, peDataOutConf, peInstructionNumberConf}), 32'd0);
    chk("midrst_in0", peDataIn0, 32'd0);
    chk("midrst_in1", peDataIn1, 32'd0);
    chk("midrst_rfrd", rfRdData, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    rstN = 1'b1;
    cyc();
    rd_rf(3'd1, v); chk("midrst_r1_kept", v, 32'd5);
    rd_rf(3'd7, v); chk("midrst_r7_unwritten", v, 32'd0);
    run(2, 1'b0, dc, cc, in0);
    chk("midrst_rerun_cyc", 32'(dc), 32'(exp_done(2)));
    rd_rf(3'd7, v); chk("midrst_rerun_r7", v, 32'd17);

`ifdef APE_SEQ_STEP_EN
    // Single-step: HALT holds until step
    step = 1'b0;
    lastInstr = 4'd1; start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k < 5; k++) cyc();
    for (int k = 5; k < 15; k++) begin
      chk("halt_hold", {29'd0, busy, done, peConfigure}, 32'd4);
      if (k < 14) cyc();
    end
    step = 1'b1; cyc(); step = 1'b0;
    chk("halt_fetch_instr", 32'(peConfigure), 32'd0);
    cyc();
    chk("halt_cfg", {28'd0, peConfigure, peInstructionNumberConf[2:0]}, 32'h9);
    cyc(); cyc(); cyc();
    chk("halt_done", 32'(done), 32'd1);
    cyc();
    chk("halt_idle", 32'(busy), 32'd0);
    step = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
